// File: rtl/quadencoder_velocity.sv
// Speed measurement behind the quadrature counter: windowed velocity, edge-to-edge
// period, direction and stall flag, all derived from the counter's signed position word.
module quadencoder_velocity #(
   parameter int BITS          = 32,
   parameter int VEL_BITS      = 24,
   parameter int PERIOD_BITS   = 24,
   parameter int WINDOW_CYCLES = 50000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [BITS-1:0]            position,
   input  logic                       pos_clear,
   output logic signed [VEL_BITS-1:0] velocity,
   output logic                       vel_valid,
   output logic [PERIOD_BITS-1:0]     period,
   output logic                       direction,
   output logic                       stalled
);

   localparam int WC_BITS = $clog2(WINDOW_CYCLES);
   localparam logic [WC_BITS-1:0] WC_LAST = WC_BITS'(WINDOW_CYCLES - 1);

   // Velocity saturation limits, sign-extended to the position width.
   localparam logic signed [BITS-1:0] VEL_MAX =
      {{(BITS-VEL_BITS+1){1'b0}}, {(VEL_BITS-1){1'b1}}};
   localparam logic signed [BITS-1:0] VEL_MIN =
      {{(BITS-VEL_BITS+1){1'b1}}, {(VEL_BITS-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_FIRST,
      S_RUN
   } pstate_t;

   logic [BITS-1:0]         pos_q;
   logic [BITS-1:0]         pos_q_d;
   logic                    clr_q;
   logic [WC_BITS-1:0]      wcnt;
   logic [BITS-1:0]         baseline;
   logic [PERIOD_BITS-1:0]  pcnt;
   pstate_t                 state;

   logic signed [BITS-1:0]  step;
   logic signed [BITS-1:0]  delta;
   logic signed [VEL_BITS-1:0] vel_sat;
   logic                    chg;
   logic                    inc;
   logic                    same_dir;
   logic                    pcnt_full;
   logic [PERIOD_BITS-1:0]  pcnt_next_sat;

   // NOTE: every signal assigned here gets a value on every path, so no latch can form.
   always_comb begin
      step          = $signed(pos_q - pos_q_d);
      // The cycle after a clear compares zero against the stale position; that is not motion.
      chg           = (step != '0) && !clr_q;
      inc           = !step[BITS-1];
      same_dir      = (inc == direction);
      pcnt_full     = (pcnt == '1);
      pcnt_next_sat = pcnt_full ? pcnt : pcnt + 1'b1;
      delta         = $signed(pos_q - baseline);
      vel_sat       = delta[VEL_BITS-1:0];
      if (delta > VEL_MAX)
         vel_sat = VEL_MAX[VEL_BITS-1:0];
      else if (delta < VEL_MIN)
         vel_sat = VEL_MIN[VEL_BITS-1:0];
   end

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pos_q     <= '0;
         pos_q_d   <= '0;
         clr_q     <= 1'b0;
         wcnt      <= '0;
         baseline  <= '0;
         velocity  <= '0;
         vel_valid <= 1'b0;
      end else begin
         pos_q     <= position;
         pos_q_d   <= pos_q;
         clr_q     <= pos_clear;
         vel_valid <= 1'b0;
         if (pos_clear) begin
            wcnt     <= '0;
            baseline <= '0;
         end else if (wcnt == WC_LAST) begin
            wcnt      <= '0;
            baseline  <= pos_q;
            velocity  <= vel_sat;
            vel_valid <= 1'b1;
         end else begin
            wcnt <= wcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         pcnt      <= '0;
         period    <= '1;
         direction <= 1'b0;
         stalled   <= 1'b1;
      end else if (pos_clear) begin
         state   <= S_IDLE;
         pcnt    <= '0;
         period  <= '1;
         stalled <= 1'b1;
      end else begin
         pcnt <= chg ? '0 : pcnt_next_sat;
         case (state)
            S_IDLE: begin
               if (chg) begin
                  state     <= S_FIRST;
                  direction <= inc;
               end
            end
            S_FIRST: begin
               if (chg) begin
                  if (same_dir) begin
                     state   <= S_RUN;
                     period  <= pcnt_next_sat;
                     stalled <= 1'b0;
                  end else begin
                     direction <= inc;
                  end
               end
            end
            S_RUN: begin
               if (chg) begin
                  if (same_dir) begin
                     period <= pcnt_next_sat;
                  end else begin
                     state     <= S_FIRST;
                     period    <= '1;
                     stalled   <= 1'b1;
                     direction <= inc;
                  end
               end else if (pcnt_full) begin
                  state   <= S_IDLE;
                  period  <= '1;
                  stalled <= 1'b1;
               end
            end
            default: begin
               state   <= S_IDLE;
               period  <= '1;
               stalled <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_quadencoder_velocity.sv
// Directed bench for quadencoder_velocity: 100-cycle window, 8-bit velocity and period
// so saturation and stall timeout are reachable in a short run.
module tb_quadencoder_velocity;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [31:0]       position;
   logic              pos_clear;
   logic signed [7:0] velocity;
   logic              vel_valid;
   logic [7:0]        period;
   logic              direction;
   logic              stalled;

   int n_vec    = 0;
   int n_miss   = 0;
   int cyc      = 0;
   int n_strobe = 0;
   int last_cyc = 0;
   int last_gap = 0;
   int last_vel = 0;

   quadencoder_velocity #(
      .BITS(32), .VEL_BITS(8), .PERIOD_BITS(8), .WINDOW_CYCLES(100)
   ) dut (
      .clk(clk), .rst_n(rst_n), .position(position), .pos_clear(pos_clear),
      .velocity(velocity), .vel_valid(vel_valid), .period(period),
      .direction(direction), .stalled(stalled)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  tag, $signed(obs), obs, $signed(exp), exp);
      end
   endtask

   // One clock; outputs are read 1 ns after the edge and every strobe is logged.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (vel_valid) begin
         n_strobe++;
         last_gap = cyc - last_cyc;
         last_cyc = cyc;
         last_vel = velocity;
      end
   endtask

   // Step position at the start of every 'every'-cycle slot; n is a multiple of every.
   task automatic run_steps(input int n, input int every, input int step);
      for (int i = 0; i < n; i++) begin
         if (i % every == 0) position = position + 32'(step);
         tick();
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      position  = 32'd1234;
      pos_clear = 1'b0;
      repeat (5) tick();
      check("rst_velocity",  32'(velocity), 32'd0);
      check("rst_vel_valid", 32'(vel_valid), 32'd0);
      check("rst_period",    32'(period), 32'hFF);
      check("rst_direction", 32'(direction), 32'd0);
      check("rst_stalled",   32'(stalled), 32'd1);
      check("rst_no_strobe", 32'(n_strobe), 32'd0);
      position = 32'd0;
      tick();
      rst_n = 1'b1;

      // Incrementing every 10 clocks.
      run_steps(10, 10, 1);
      check("up_first_stalled", 32'(stalled), 32'd1);
      check("up_first_dir",     32'(direction), 32'd1);
      check("up_first_period",  32'(period), 32'hFF);
      run_steps(10, 10, 1);
      check("up_period",  32'(period), 32'd10);
      check("up_stalled", 32'(stalled), 32'd0);
      run_steps(380, 10, 1);
      check("up_strobes", 32'(n_strobe), 32'd4);
      check("up_velocity", 32'(last_vel), 32'd10);
      check("up_gap", 32'(last_gap), 32'd100);

      // Reversal, then decrementing every 4 clocks.
      n_strobe = 0;
      run_steps(4, 4, -1);
      check("rev_period",  32'(period), 32'hFF);
      check("rev_stalled", 32'(stalled), 32'd1);
      check("rev_dir",     32'(direction), 32'd0);
      run_steps(4, 4, -1);
      check("dn_period",  32'(period), 32'd4);
      check("dn_stalled", 32'(stalled), 32'd0);
      run_steps(392, 4, -1);
      check("dn_strobes",  32'(n_strobe), 32'd4);
      check("dn_velocity", 32'(last_vel), -32'sd25);
      check("dn_gap",      32'(last_gap), 32'd100);

      // Stall timeout: last change detected 255 clocks ago, one more clock times out.
      run_steps(253, 1, 0);
      check("stall_pre_flag",   32'(stalled), 32'd0);
      check("stall_pre_period", 32'(period), 32'd4);
      run_steps(1, 1, 0);
      check("stall_flag",   32'(stalled), 32'd1);
      check("stall_period", 32'(period), 32'hFF);

      // Saturation in both directions.
      position = position + 32'd300;
      run_steps(46, 1, 0);
      check("sat_hi_valid", 32'(vel_valid), 32'd1);
      check("sat_hi_vel",   32'(last_vel), 32'd127);
      position = position - 32'd600;
      run_steps(100, 1, 0);
      check("sat_lo_valid", 32'(vel_valid), 32'd1);
      check("sat_lo_vel",   32'(last_vel), -32'sd128);

      // pos_clear on the terminal-count cycle.
      run_steps(90, 10, 1);
      run_steps(9, 1, 0);
      check("pre_clr_stalled", 32'(stalled), 32'd0);
      check("pre_clr_period",  32'(period), 32'd10);
      position  = 32'd0;
      pos_clear = 1'b1;
      tick();
      pos_clear = 1'b0;
      position  = 32'd3;
      check("clr_no_valid", 32'(vel_valid), 32'd0);
      check("clr_vel_hold", 32'(velocity), -32'sd128);
      check("clr_stalled",  32'(stalled), 32'd1);
      run_steps(99, 1, 0);
      check("clr_no_early", 32'(vel_valid), 32'd0);
      tick();
      check("clr_next_valid", 32'(vel_valid), 32'd1);
      check("clr_next_vel",   32'(velocity), 32'd3);
      check("clr_next_gap",   32'(last_gap), 32'd200);

      // Position wrap 0x7FFFFFFE -> 0x80000002 across one window.
      position = 32'h7FFF_FFFE;
      run_steps(100, 1, 0);
      check("wrap_pre_vel", 32'(velocity), 32'd127);
      run_steps(100, 25, 1);
      check("wrap_valid",  32'(vel_valid), 32'd1);
      check("wrap_vel",    32'(velocity), 32'd4);
      check("wrap_dir",    32'(direction), 32'd1);
      check("wrap_period", 32'(period), 32'd25);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
